// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, shadow-entry layout and FSM encoding for the RV32I pipeline controller.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_LUI    = 7'd55;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } shadow_t;

  typedef enum logic {ST_RUN, ST_DWAIT} ctrl_state_e;

  // True when a live writer in shadow s produces a register the IF/ID instruction reads.
  function automatic logic src_hit(input shadow_t s, input logic re1, input logic [4:0] rs1,
                                   input logic re2, input logic [4:0] rs2);
    return s.valid && s.we && ((re1 && (rs1 == s.rd)) || (re2 && (rs2 == s.rd)));
  endfunction

endpackage

// File: rtl/rv_use_decode.sv
// Opcode to register-usage decode; purely combinational, no state.
module rv_use_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       re1,
  output logic       re2,
  output logic       we,
  output logic       is_load
);

  always_comb begin
    re1     = 1'b0;
    re2     = 1'b0;
    we      = 1'b0;
    is_load = 1'b0;
    case (opcode)
      OP_LOAD:   begin re1 = 1'b1; we = 1'b1; is_load = 1'b1; end
      OP_STORE:  begin re1 = 1'b1; re2 = 1'b1; end
      OP_RTYPE:  begin re1 = 1'b1; re2 = 1'b1; we = 1'b1; end
      OP_BRANCH: begin re1 = 1'b1; re2 = 1'b1; end
      OP_IMM:    begin re1 = 1'b1; we = 1'b1; end
      OP_JAL:    we = 1'b1;
      OP_LUI:    we = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline controller: zero-latency enables/flushes from shadow rd tracking, memory freeze,
// timeout flag and stall counter. PIPE_HAZARD_FWD_EN limits interlock to load-use on EX.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit          REGFILE_WT  = 1'b0,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        stall,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_TIMEOUT);

  ctrl_state_e   state_q, state_d;
  shadow_t       ex_q, mem_q, wb_q, id_entry;
  logic [CW-1:0] wait_q, wait_d;
  logic          re1, re2, we_raw, ld_raw;
  logic          use1, use2, hazard, freeze, adv, ex_bubble;
  logic [4:0]    rd, rs1, rs2;
  logic          unused_bits;

  assign rd  = id_instr[11:7];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign unused_bits = ^{id_instr[31:25], id_instr[14:12], wb_q};

  rv_use_decode u_dec (
    .opcode  (id_instr[6:0]),
    .re1     (re1),
    .re2     (re2),
    .we      (we_raw),
    .is_load (ld_raw)
  );

  // x0 never reads as a dependency nor counts as a write.
  assign use1           = id_valid && re1 && (rs1 != 5'd0);
  assign use2           = id_valid && re2 && (rs2 != 5'd0);
  assign id_entry.valid = id_valid;
  assign id_entry.rd    = rd;
  assign id_entry.we    = id_valid && we_raw && (rd != 5'd0);
  assign id_entry.load  = id_valid && ld_raw;

`ifdef PIPE_HAZARD_FWD_EN
  assign hazard = ex_q.load && src_hit(ex_q, use1, rs1, use2, rs2);
`else
  assign hazard = src_hit(ex_q, use1, rs1, use2, rs2) || src_hit(mem_q, use1, rs1, use2, rs2) ||
                  ((REGFILE_WT == 1'b0) && src_hit(wb_q, use1, rs1, use2, rs2));
`endif

  assign freeze = mem_req && !mem_ready;

  always_comb begin
    state_d     = ST_RUN;
    wait_d      = '0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    stall       = 1'b0;
    adv         = 1'b0;
    ex_bubble   = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      state_d = ST_DWAIT;
      if (state_q == ST_RUN)
        wait_d = CW'(1);
      else
        wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + CW'(1);
    end else if (ex_branch_taken) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      adv         = 1'b1;
      ex_bubble   = 1'b1;
    end else if (hazard) begin
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      stall       = 1'b1;
      adv         = 1'b1;
      ex_bubble   = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      adv       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      wait_q       <= '0;
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (freeze && (wait_d == WAIT_MAX))
        mem_err <= 1'b1;
      if (adv) begin
        ex_q  <= ex_bubble ? '0 : id_entry;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected control vectors queued at drive, checked at negedge.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI5 = 32'h0010_0293;  // addi x5,x0,1
  localparam logic [31:0] ADD6  = 32'h0052_8333;  // add  x6,x5,x5
  localparam logic [31:0] LW7   = 32'h0000_A383;  // lw   x7,0(x1)
  localparam logic [31:0] ADD8  = 32'h0003_8433;  // add  x8,x7,x0
  localparam logic [31:0] ADD1  = 32'h0000_00B3;  // add  x1,x0,x0

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, stall, mem_err}
  localparam logic [7:0] NORM  = 8'b1100_1100;
  localparam logic [7:0] STL   = 8'b0001_1110;
  localparam logic [7:0] BRN   = 8'b1111_1100;
  localparam logic [7:0] FRZ   = 8'b0000_0000;
  localparam logic [7:0] RST_C = 8'b0011_0000;
  localparam logic [7:0] ERR   = 8'b0000_0001;

`ifdef PIPE_HAZARD_FWD_EN
  localparam int RAW_STALLS = 0;
  localparam int LU_STALLS  = 1;
  localparam int BR_STALLS  = 0;
`else
  localparam int RAW_STALLS = 3;
  localparam int LU_STALLS  = 3;
  localparam int BR_STALLS  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid, ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, stall, mem_err;
  logic [31:0] stall_cycles;
  logic [7:0]  ctl_obs;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGFILE_WT(1'b0), .MEM_TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_instr        (id_instr),
    .id_valid        (id_valid),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .stall           (stall),
    .mem_err         (mem_err),
    .stall_cycles    (stall_cycles)
  );

  assign ctl_obs = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, stall, mem_err};

  typedef struct {
    string       tag;
    logic [7:0]  ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val(e.tag, {24'd0, ctl_obs}, {24'd0, e.ctl});
      check_val({e.tag, "/cnt"}, stall_cycles, e.cnt);
    end
  end

  task automatic cyc(input string tag, input logic [31:0] instr, input bit vld, input bit br,
                     input bit req, input bit rdy, input bit r, input logic [7:0] ctl);
    exp_t e;
    rst             = r;
    id_instr        = instr;
    id_valid        = vld;
    ex_branch_taken = br;
    mem_req         = req;
    mem_ready       = rdy;
    e.tag = tag;
    e.ctl = ctl;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (r) exp_cnt = 32'd0;
    else if (ctl[1]) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n, input logic [7:0] ctl);
    for (int i = 0; i < n; i++) cyc(tag, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ctl);
  endtask

  initial begin
    rst = 1'b1; id_instr = NOP; id_valid = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RST_C);

    // RAW behind addi
    cyc("t1_prod", ADDI5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    for (int i = 0; i < RAW_STALLS; i++) cyc("t1_stall", ADD6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    cyc("t1_issue", ADD6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    idle("t1_drain", 3, NORM);

    // load-use
    cyc("t2_prod", LW7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    for (int i = 0; i < LU_STALLS; i++) cyc("t2_stall", ADD8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    cyc("t2_issue", ADD8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    idle("t2_drain", 3, NORM);

    // taken branch beats a pending hazard and bubbles the EX shadow
    cyc("t3_prod", LW7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    cyc("t3_branch", ADD8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BRN);
    for (int i = 0; i < BR_STALLS; i++) cyc("t3_stall", ADD8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    cyc("t3_issue", ADD8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    idle("t3_drain", 3, NORM);

    // memory wait freezes over a hazard; shadows must hold through the freeze
    cyc("t4_prod", ADDI5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    for (int i = 0; i < 4; i++) cyc("t4_freeze", ADD6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    cyc("t4_resume", ADD6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, (RAW_STALLS > 0) ? STL : NORM);
    for (int i = 1; i < RAW_STALLS; i++) cyc("t4_stall", ADD6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, STL);
    cyc("t4_issue", ADD6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    idle("t4_drain", 3, NORM);
    for (int i = 0; i < 2; i++) cyc("t4_brfrz", ADD6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FRZ);
    cyc("t4_brgo", ADD6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, BRN);
    idle("t4_drain2", 3, NORM);

    // timeout at 8 wait cycles, sticky afterwards
    for (int i = 0; i < 10; i++)
      cyc("t5_wait", NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, (i >= 8) ? (FRZ | ERR) : FRZ);
    idle("t5_sticky", 3, NORM | ERR);

    // reset mid-wait clears mem_err and the wait counter
    for (int i = 0; i < 2; i++) cyc("t6_dwait", NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ | ERR);
    cyc("t6_rst", NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, RST_C | ERR);
    cyc("t6_run", NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    for (int i = 0; i < 7; i++) cyc("t6_rewait", NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ);
    cyc("t6_release", NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NORM);

    // x0 writer and x0 readers never interlock
    cyc("t6_x0w", NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    cyc("t6_x0r", ADD1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    cyc("t6_x0r2", ADD1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    idle("t6_drain", 2, NORM);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
